axil_write_arbiter: RTL

Shares one AXI4-Lite write master port (AW/W/B channels) between `N_REQ` HLS-generated requester kernels. Each requester presents a word index and 32-bit data. The block arbitrates round-robin, shifts the index to a byte address, and sequences AW/W/B so that each requester sees one transaction at a time. It sits between the generated kernels and the `s_axil_*` slave port of the shared register/memory block.

---
 rtl/axil_write_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/axil_write_arbiter.sv
// axil_write_arbiter: round-robin sharing of one AXI4-Lite write port (AW/W/B) among N_REQ requesters.
// Optional macro AXIL_WR_ERR_STICKY_EN builds a sticky err flag for non-OKAY write responses.
module axil_write_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*32-1:0]   req_idx,
    input  logic [N_REQ*32-1:0]   req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      req_done,
    output logic [1:0]            req_resp,
    output logic [ADDR_W-1:0]     s_axil_awaddr,
    output logic [2:0]            s_axil_awprot,
    output logic                  s_axil_awvalid,
    input  logic                  s_axil_awready,
    output logic [31:0]           s_axil_wdata,
    output logic [3:0]            s_axil_wstrb,
    output logic                  s_axil_wvalid,
    input  logic                  s_axil_wready,
    input  logic [1:0]            s_axil_bresp,
    input  logic                  s_axil_bvalid,
    output logic                  s_axil_bready,
    output logic                  err
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE_LSB = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  r_gnt;
    logic [PTR_W-1:0]  w_gnt;
    logic              r_aw_done;
    logic              r_w_done;
    logic [ADDR_W-1:0] r_awaddr;
    logic [31:0]       r_wdata;
    logic [N_REQ-1:0]  r_done;
    logic [1:0]        r_resp;
    logic              w_found;
    logic [31:0]       w_idx;
    logic [31:0]       w_data;
    logic [33:0]       w_byte_addr;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_xfer_end;
    logic              w_b_hs;
    logic [N_REQ-1:0]  w_ready;
    int                w_cand;

    // Round-robin pick: first valid requester at or after r_ptr, wrapping modulo N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = 32'd0;
        w_data  = 32'd0;
        w_cand  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = (int'(r_ptr) + k) % N_REQ;
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_gnt   = PTR_W'(w_cand);
                w_idx   = req_idx[32*w_cand +: 32];
                w_data  = req_data[32*w_cand +: 32];
            end else begin
                w_found = w_found;
            end
        end
    end

    assign w_byte_addr = {w_idx, 2'b00};
    assign w_aw_hs     = s_axil_awvalid & s_axil_awready;
    assign w_w_hs      = s_axil_wvalid & s_axil_wready;
    // Channels finish independently; the transfer ends once both have (or do this cycle).
    assign w_xfer_end  = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
    assign w_b_hs      = s_axil_bready & s_axil_bvalid;

    // Next-state decode and the combinational grant strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_XFER;
                    w_ready     = ONE_LSB << w_gnt;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (w_xfer_end) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_XFER;
                end
            end
            ST_RESP: begin
                if (w_b_hs) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, captured payload, channel flags and the requester-side completion pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= 32'd0;
            r_done    <= '0;
            r_resp    <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt    <= w_gnt;
                        r_awaddr <= w_byte_addr[ADDR_W-1:0];
                        r_wdata  <= w_data;
                    end else begin
                        r_gnt <= r_gnt;
                    end
                end
                ST_XFER: begin
                    if (w_xfer_end) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end else begin
                        r_aw_done <= r_aw_done | w_aw_hs;
                        r_w_done  <= r_w_done | w_w_hs;
                    end
                end
                ST_RESP: begin
                    if (w_b_hs) begin
                        r_done <= ONE_LSB << r_gnt;
                        r_resp <= s_axil_bresp;
                        r_ptr  <= (r_gnt == PTR_W'(N_REQ-1)) ? '0 : r_gnt + PTR_W'(1);
                    end else begin
                        r_resp <= r_resp;
                    end
                end
                default: r_done <= '0;
            endcase
        end
    end

    assign req_ready      = w_ready;
    assign req_done       = r_done;
    assign req_resp       = r_resp;
    assign s_axil_awaddr  = r_awaddr;
    assign s_axil_awprot  = 3'b000;
    assign s_axil_awvalid = (r_state == ST_XFER) & ~r_aw_done;
    assign s_axil_wdata   = r_wdata;
    assign s_axil_wstrb   = 4'hF;
    assign s_axil_wvalid  = (r_state == ST_XFER) & ~r_w_done;
    assign s_axil_bready  = (r_state == ST_RESP);

`ifdef AXIL_WR_ERR_STICKY_EN
    logic r_err;

    // Sticky flag raised by any consumed SLVERR/DECERR; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_b_hs && (s_axil_bresp != 2'b00)) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
